// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline stages.
// ALU op codes, forwarding selects and datapath widths.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Memory stage wins when both later stages write the source register.
    function automatic logic [1:0] fwd_sel(
        input logic              regwrite_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              regwrite_w,
        input logic [REG_AW-1:0] rd_w,
        input logic [REG_AW-1:0] rs
    );
        if (regwrite_m && rd_m != '0 && rd_m == rs)
            return FWD_MEM;
        else if (regwrite_w && rd_w != '0 && rd_w == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU for the execute stage.
// Unlisted op codes produce zero.
module alu
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}},
                               $signed(SrcA) < $signed(SrcB)};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: forwarding, ALU, branch resolution, EX/MEM register.
// Define FWD_INTERNAL_EN to derive forwarding selects locally.
module execute_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RS1_E,
    input  logic [REG_AW-1:0] RS2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemReadM,
    output logic              ResultSrcM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RD_M
);

    logic              r_regwrite_m;
    logic              r_memwrite_m;
    logic              r_memread_m;
    logic              r_resultsrc_m;
    logic [XLEN-1:0]   r_alu_m;
    logic [XLEN-1:0]   r_wd_m;
    logic [XLEN-1:0]   r_pc4_m;
    logic [REG_AW-1:0] r_rd_m;

    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_wd_e;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_zero;
    logic              w_unused;

`ifdef FWD_INTERNAL_EN
    assign w_fwd_a  = fwd_sel(r_regwrite_m, r_rd_m,
                              RegWriteW, RDW, RS1_E);
    assign w_fwd_b  = fwd_sel(r_regwrite_m, r_rd_m,
                              RegWriteW, RDW, RS2_E);
    assign w_unused = ^{ForwardAE, ForwardBE};
`else
    assign w_fwd_a  = ForwardAE;
    assign w_fwd_b  = ForwardBE;
    assign w_unused = ^{RS1_E, RS2_E, RegWriteW, RDW};
`endif

    always_comb begin
        w_src_a = RD1_E;
        case (w_fwd_a)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_m;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        w_wd_e = RD2_E;
        case (w_fwd_b)
            FWD_WB:  w_wd_e = ResultW;
            FWD_MEM: w_wd_e = r_alu_m;
            default: w_wd_e = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_wd_e;

    alu u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_res),
        .Zero       (w_zero)
    );

    // beq arrives as sub, so equality shows up as a zero result.
    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_memread_m   <= 1'b0;
            r_resultsrc_m <= 1'b0;
            r_alu_m       <= '0;
            r_wd_m        <= '0;
            r_pc4_m       <= '0;
            r_rd_m        <= '0;
        end else begin
            r_regwrite_m  <= RegWriteE;
            r_memwrite_m  <= MemWriteE;
            r_memread_m   <= MemReadE;
            r_resultsrc_m <= ResultSrcE;
            r_alu_m       <= w_alu_res;
            r_wd_m        <= w_wd_e;
            r_pc4_m       <= PCPlus4E;
            r_rd_m        <= RD_E;
        end
    end

    assign RegWriteM  = r_regwrite_m;
    assign MemWriteM  = r_memwrite_m;
    assign MemReadM   = r_memread_m;
    assign ResultSrcM = r_resultsrc_m;
    assign ALUResultM = r_alu_m;
    assign WriteDataM = r_wd_m;
    assign PCPlus4M   = r_pc4_m;
    assign RD_M       = r_rd_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed steps then random
// instructions against a behavioural model of the EX stage.
module tb_execute_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, MemReadE, ResultSrcE;
    logic        BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RD_M(RD_M)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected EX/MEM contents
    logic        m_rw, m_mw, m_mr, m_rs;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_sel(input logic [1:0] ext,
                                           input logic [4:0] rs);
`ifdef FWD_INTERNAL_EN
        if (m_rw && m_rd != 0 && m_rd == rs) return 2'd2;
        if (RegWriteW && RDW != 0 && RDW == rs) return 2'd1;
        return 2'd0;
`else
        if (rs == 5'd31) return ext;
        return ext;
`endif
    endfunction

    function automatic logic [31:0] ref_opnd(input logic [1:0] s,
                                             input logic [31:0] rf);
        if (s == 2'd1) return ResultW;
        if (s == 2'd2) return m_alu;
        return rf;
    endfunction

    task automatic clr();
        rst = 0; RegWriteE = 0; MemWriteE = 0; MemReadE = 0;
        ResultSrcE = 0; BranchE = 0; ALUSrcE = 0; ALUControlE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        RS1_E = 0; RS2_E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0;
        RegWriteW = 0; RDW = 0; ResultW = 0;
    endtask

    task automatic cycle(input string tag);
        logic [31:0] a, wd, b, res;
        #1;
        a   = ref_opnd(ref_sel(ForwardAE, RS1_E), RD1_E);
        wd  = ref_opnd(ref_sel(ForwardBE, RS2_E), RD2_E);
        b   = ALUSrcE ? Imm_Ext_E : wd;
        res = ref_alu(ALUControlE, a, b);
        chk({tag, "_pcsrc"}, {31'd0, PCSrcE},
            {31'd0, BranchE && (res == 0)});
        chk({tag, "_target"}, PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        if (rst) begin
            m_rw = 0; m_mw = 0; m_mr = 0; m_rs = 0;
            m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        end else begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_mr = MemReadE;
            m_rs = ResultSrcE; m_alu = res; m_wd = wd;
            m_pc4 = PCPlus4E; m_rd = RD_E;
        end
        #1;
        chk({tag, "_rwm"}, {31'd0, RegWriteM}, {31'd0, m_rw});
        chk({tag, "_mwm"}, {31'd0, MemWriteM}, {31'd0, m_mw});
        chk({tag, "_mrm"}, {31'd0, MemReadM}, {31'd0, m_mr});
        chk({tag, "_rsm"}, {31'd0, ResultSrcM}, {31'd0, m_rs});
        chk({tag, "_alum"}, ALUResultM, m_alu);
        chk({tag, "_wdm"}, WriteDataM, m_wd);
        chk({tag, "_pc4m"}, PCPlus4M, m_pc4);
        chk({tag, "_rdm"}, {27'd0, RD_M}, {27'd0, m_rd});
    endtask

    initial begin
        clr();
        m_rw = 0; m_mw = 0; m_mr = 0; m_rs = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        @(posedge clk);
        #1;

        // reset with live controls
        clr(); rst = 1; RegWriteE = 1; MemWriteE = 1; RD_E = 5;
        RD1_E = 32'h55; Imm_Ext_E = 3; ALUSrcE = 1; PCPlus4E = 32'h44;
        cycle("reset");
        chk("reset_lit_alu", ALUResultM, 32'd0);
        chk("reset_lit_rw", {31'd0, RegWriteM}, 32'd0);

        // addi x1, x0, 10
        clr(); RD1_E = 0; Imm_Ext_E = 10; ALUSrcE = 1; RD_E = 1;
        RegWriteE = 1; PCPlus4E = 32'h4;
        cycle("addi");
        chk("addi_lit", ALUResultM, 32'd10);
        chk("addi_rd", {27'd0, RD_M}, 32'd1);

        // add using memory-stage forward
        clr(); RS1_E = 1; RD1_E = 0; RD2_E = 20; RD_E = 2;
        RegWriteE = 1;
`ifndef FWD_INTERNAL_EN
        ForwardAE = 2'b10;
`endif
        cycle("memfwd");
        chk("memfwd_lit", ALUResultM, 32'd30);

        // x3 = 9, then both stages hold x3
        clr(); Imm_Ext_E = 9; ALUSrcE = 1; RD_E = 3; RegWriteE = 1;
        cycle("mk_x3");
        clr(); RS1_E = 3; ALUSrcE = 1; RDW = 3; ResultW = 7;
        RegWriteW = 1; RD_E = 3; RegWriteE = 1;
`ifndef FWD_INTERNAL_EN
        ForwardAE = 2'b10;
`endif
        cycle("prio");
        chk("prio_lit", ALUResultM, 32'd9);

`ifndef FWD_INTERNAL_EN
        clr(); RS1_E = 3; ALUSrcE = 1; RDW = 3; ResultW = 7;
        RegWriteW = 1; ForwardAE = 2'b01;
        cycle("wbfwd");
        chk("wbfwd_lit", ALUResultM, 32'd7);
`endif

        // x0 destinations never forward
        clr(); Imm_Ext_E = 55; ALUSrcE = 1; RD_E = 0; RegWriteE = 1;
        cycle("mk_x0");
        clr(); RS1_E = 0; RD1_E = 4; Imm_Ext_E = 1; ALUSrcE = 1;
        RDW = 0; RegWriteW = 1; ResultW = 99;
        cycle("x0");
        chk("x0_lit", ALUResultM, 32'd5);

        // beq taken / not taken
        clr(); BranchE = 1; ALUControlE = 3'b001; RD1_E = 5; RD2_E = 5;
        PCE = 32'h18; Imm_Ext_E = 32'h8;
        #1;
        chk("beq_lit_src", {31'd0, PCSrcE}, 32'd1);
        chk("beq_lit_tgt", PCTargetE, 32'h20);
        cycle("beq_t");
        clr(); BranchE = 1; ALUControlE = 3'b001; RD1_E = 5; RD2_E = 6;
        PCE = 32'h18; Imm_Ext_E = 32'h8;
        #1;
        chk("beq_nt_lit", {31'd0, PCSrcE}, 32'd0);
        cycle("beq_nt");

        // slt -1 < 1
        clr(); ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        RD_E = 4; RegWriteE = 1;
        cycle("slt");
        chk("slt_lit", ALUResultM, 32'd1);

        // sw
        clr(); RD1_E = 32'h100; RD2_E = 32'h1234; Imm_Ext_E = 4;
        ALUSrcE = 1; MemWriteE = 1;
        cycle("sw");
        chk("sw_wd", WriteDataM, 32'h1234);
        chk("sw_addr", ALUResultM, 32'h104);
        chk("sw_mw", {31'd0, MemWriteM}, 32'd1);

        // bubble
        clr(); RD1_E = 32'h77; RD2_E = 32'h88;
        cycle("bubble");

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            clr();
            rst         = ($urandom_range(0, 15) == 0);
            RegWriteE   = $urandom_range(0, 1) == 1;
            MemWriteE   = $urandom_range(0, 1) == 1;
            MemReadE    = $urandom_range(0, 1) == 1;
            ResultSrcE  = $urandom_range(0, 1) == 1;
            BranchE     = $urandom_range(0, 1) == 1;
            ALUSrcE     = $urandom_range(0, 1) == 1;
            ALUControlE = 3'($urandom_range(0, 7));
            RD1_E       = $urandom;
            RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
            Imm_Ext_E   = $urandom;
            PCE         = $urandom;
            PCPlus4E    = $urandom;
            RS1_E       = 5'($urandom_range(0, 3));
            RS2_E       = 5'($urandom_range(0, 3));
            RD_E        = 5'($urandom_range(0, 3));
            ForwardAE   = 2'($urandom_range(0, 3));
            ForwardBE   = 2'($urandom_range(0, 3));
            RegWriteW   = $urandom_range(0, 1) == 1;
            RDW         = 5'($urandom_range(0, 3));
            ResultW     = $urandom;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
